brick_field_writer: RTL and testbench
=====================================

Name: brick_field_writer

Overview:
- Owns and writes the 12x16 playfield bitmap `data` (bit index = row*16 + col) that the ball-movement logic reads.
- Loads brick rows and draws the paddle into row 11.
- Removes bricks the ball strikes on each ball step and keeps score, bricks remaining, and level/game status.
- Sits between game control (start, paddle position) and ball movement: its `data` output feeds the ball's collision lookup, and it takes the ball's position and direction back.

Parameters:
- BRICK_TOP, 1: first brick row.
- BRICK_ROWS, 4: number of brick rows; BRICK_TOP+BRICK_ROWS <= 11.
- PADDLE_W, 4: paddle width in columns, 1..16.
- SCORE_W, 8: score counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a level load.
- tick  in  1  one-cycle pulse, asserted on the same edge the ball logic evaluates a step.
- Ball_rowIndex  in  4  ball row.
- Ball_colIndex  in  4  ball column.
- Ball_direction  in  2  00 UP_RIGHT(row-1,col-1), 01 UP_LEFT(row-1,col+1), 10 DOWN_RIGHT(row+1,col-1), 11 DOWN_LEFT(row+1,col+1).
- paddle_col  in  4  leftmost (lowest-index) paddle column.
- data  out  192  playfield bitmap.
- score  out  SCORE_W  bricks destroyed.
- bricks_left  out  8  bricks remaining.
- level_clear  out  1  high while in CLEAR.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset (async, while high): data=0, score=0, bricks_left=0, level_clear=0, game_over=0, state=IDLE.
- States and transitions:
  - IDLE: waits for start.
  - LOAD: BRICK_ROWS cycles; counter k=0..BRICK_ROWS-1.
    - k=0: rows 0..10 cleared to 0, then row BRICK_TOP written full.
    - Each later cycle writes row BRICK_TOP+k.
    - After the last row: bricks_left = popcount of the loaded pattern (64 default), state becomes PLAY.
  - PLAY: processes ticks (below).
  - CLEAR: entered when bricks_left reaches 0.
  - OVER: entered when a tick sees Ball_rowIndex==11.
- start handling:
  - start in any state goes to LOAD.
  - score cleared only when start comes from IDLE or OVER; from CLEAR it is kept (next level).
  - start and tick on the same edge: start wins and the tick is ignored.
- Paddle drawing:
  - Row 11 is rewritten every cycle in LOAD, PLAY, and CLEAR.
  - Bits set = PADDLE_W consecutive columns from pc = min(paddle_col, 16-PADDLE_W); all other row-11 bits are 0.
  - Row 11 is frozen in OVER and IDLE.
- Tick in PLAY, computed from current inputs and current data:
  - Candidates: V=(r+dr, c), H=(r, c+dc), D=(r+dr, c+dc), where dr/dc=±1 per direction.
  - Candidate coordinates use 5-bit signed arithmetic; a candidate outside rows 0..11 or cols 0..15 is ignored (no 4-bit wrap).
  - A candidate is a brick if its bit is 1 and its row is in [BRICK_TOP, BRICK_TOP+BRICK_ROWS-1]. Paddle and other cells are never cleared.
  - If V and/or H is a brick, clear those (1 or 2 cells). Otherwise, if D is a brick, clear D.
  - n = cells cleared (0..2).
  - score += n, saturating at all-ones.
  - bricks_left -= n (never underflows; n <= bricks_left by construction).
- Latency: clears, score, and bricks_left update on the tick edge and are visible on data the next cycle.
- End-of-tick priority:
  - bricks_left becomes 0: go to CLEAR (takes priority even if Ball_rowIndex==11 on that tick).
  - Else if Ball_rowIndex==11: go to OVER.
- Ticks outside PLAY are ignored.
- Reset mid-LOAD or mid-PLAY aborts immediately to the reset values.

Optional Feature:
- Macro: BRICK_FIELD_CHECKER_EN.
- Defined: LOAD writes only cells where (row+col) is even within the brick rows. bricks_left = BRICK_ROWS*8 (32 default); all other behaviour unchanged.
- Undefined: brick rows are loaded solid (16 bricks per row).

Test Plan:
- Reset, then start, paddle_col=6, 4 cycles:
  - data rows 1..4 = 16'hFFFF, rows 0 and 5..10 = 0, row 11 = 16'h03C0.
  - bricks_left=64, score=0.
- After load, tick with ball (5,7) dir UP_RIGHT:
  - bit 4*16+7 cleared next cycle; score=1, bricks_left=63.
  - Next tick, same ball position: V empty, H (5,6) not brick, so D (4,6) cleared; score=2.
- Tick with ball (0,0) dir UP_RIGHT: all candidates out of range, data unchanged, score unchanged.
- paddle_col=15: row 11 = 16'hF000 (clamped to 12). start asserted with tick on the same edge: LOAD entered, no clear applied.
- Tick with Ball_rowIndex=11 in PLAY: game_over=1 next cycle; further ticks change nothing. start then gives score=0 and a reload.
- Drive ticks clearing all 64 bricks: on the final clear bricks_left=0, level_clear=1, score=64. start from CLEAR reloads with score still 64. With BRICK_FIELD_CHECKER_EN defined, load gives bricks_left=32 and row 1 = 16'hAAAA.

Source files
------------

// File: rtl/brick_field_writer.sv
// Playfield owner: loads brick rows, draws the paddle into row 11, clears struck bricks and
// tracks score/status. Define BRICK_FIELD_CHECKER_EN to load a checkerboard brick pattern.
module brick_field_writer #(
    parameter int BRICK_TOP  = 1,
    parameter int BRICK_ROWS = 4,
    parameter int PADDLE_W   = 4,
    parameter int SCORE_W    = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               tick,
    input  logic [3:0]         Ball_rowIndex,
    input  logic [3:0]         Ball_colIndex,
    input  logic [1:0]         Ball_direction,
    input  logic [3:0]         paddle_col,
    output logic [191:0]       data,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         bricks_left,
    output logic               level_clear,
    output logic               game_over
);
    typedef enum logic [2:0] {IDLE, LOAD, PLAY, CLEAR, OVER} state_t;

`ifdef BRICK_FIELD_CHECKER_EN
    localparam logic [15:0] PAT_EVEN    = 16'h5555;
    localparam logic [15:0] PAT_ODD     = 16'hAAAA;
    localparam logic [7:0]  BRICK_TOTAL = 8'(BRICK_ROWS * 8);
`else
    localparam logic [15:0] PAT_EVEN    = 16'hFFFF;
    localparam logic [15:0] PAT_ODD     = 16'hFFFF;
    localparam logic [7:0]  BRICK_TOTAL = 8'(BRICK_ROWS * 16);
`endif
    localparam logic signed [5:0] ROW_LO    = 6'(BRICK_TOP);
    localparam logic signed [5:0] ROW_HI    = 6'(BRICK_TOP + BRICK_ROWS - 1);
    localparam logic [15:0]       PAD_MASK  = 16'((17'd1 << PADDLE_W) - 17'd1);
    localparam logic [4:0]        PC_MAX    = 5'(16 - PADDLE_W);
    localparam logic [3:0]        K_LAST    = 4'(BRICK_ROWS - 1);
    localparam logic [SCORE_W:0]  SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};

    state_t               state_q, state_d;
    logic [3:0]           k_q, k_d;
    logic [191:0]         data_q, data_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [7:0]           left_q, left_d;
    logic                 level_clear_q, game_over_q;

    logic signed [5:0]    dr, dc, row_s, col_s, v_r, h_c;
    logic                 v_b, h_b, d_b, clr_v, clr_h, clr_d;
    logic [1:0]           n;
    logic [SCORE_W:0]     sum;
    logic [3:0]           pc, load_row;
    logic [15:0]          paddle_row;

    // Brick rows always lie inside the field, so the row window also rejects out-of-range rows.
    function automatic logic in_bricks(input logic signed [5:0] r, input logic signed [5:0] c);
        return (r >= ROW_LO) && (r <= ROW_HI) && (c >= 6'sd0) && (c <= 6'sd15);
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        data_d  = data_q;
        score_d = score_q;
        left_d  = left_q;

        dr    = Ball_direction[1] ? 6'sd1 : -6'sd1;
        dc    = Ball_direction[0] ? 6'sd1 : -6'sd1;
        row_s = $signed({2'b00, Ball_rowIndex});
        col_s = $signed({2'b00, Ball_colIndex});
        v_r   = row_s + dr;
        h_c   = col_s + dc;
        v_b   = in_bricks(v_r, col_s) && data_q[{v_r[3:0], Ball_colIndex}];
        h_b   = in_bricks(row_s, h_c) && data_q[{Ball_rowIndex, h_c[3:0]}];
        d_b   = in_bricks(v_r, h_c) && data_q[{v_r[3:0], h_c[3:0]}];
        clr_v = v_b;
        clr_h = h_b;
        clr_d = d_b && !v_b && !h_b;
        n     = {1'b0, clr_v} + {1'b0, clr_h} + {1'b0, clr_d};
        sum   = {1'b0, score_q} + {{(SCORE_W-1){1'b0}}, n};

        pc         = ({1'b0, paddle_col} > PC_MAX) ? PC_MAX[3:0] : paddle_col;
        paddle_row = PAD_MASK << pc;
        load_row   = 4'(BRICK_TOP) + k_q;

        if (state_q == LOAD || state_q == PLAY || state_q == CLEAR)
            data_d[176 +: 16] = paddle_row;

        if (start) begin
            state_d = LOAD;
            k_d     = '0;
            if (state_q == IDLE || state_q == OVER)
                score_d = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (k_q == 4'd0)
                        data_d[175:0] = '0;
                    data_d[{load_row, 4'b0000} +: 16] = load_row[0] ? PAT_ODD : PAT_EVEN;
                    if (k_q == K_LAST) begin
                        left_d  = BRICK_TOTAL;
                        state_d = PLAY;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        if (clr_v) data_d[{v_r[3:0], Ball_colIndex}] = 1'b0;
                        if (clr_h) data_d[{Ball_rowIndex, h_c[3:0]}] = 1'b0;
                        if (clr_d) data_d[{v_r[3:0], h_c[3:0]}] = 1'b0;
                        score_d = (sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : sum[SCORE_W-1:0];
                        left_d  = left_q - {6'b000000, n};
                        // Clearing the last brick outranks the ball reaching the paddle row.
                        if (left_d == 8'd0)
                            state_d = CLEAR;
                        else if (Ball_rowIndex == 4'd11)
                            state_d = OVER;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            k_q           <= '0;
            data_q        <= '0;
            score_q       <= '0;
            left_q        <= '0;
            level_clear_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            data_q        <= data_d;
            score_q       <= score_d;
            left_q        <= left_d;
            level_clear_q <= (state_d == CLEAR);
            game_over_q   <= (state_d == OVER);
        end
    end

    assign data        = data_q;
    assign score       = score_q;
    assign bricks_left = left_q;
    assign level_clear = level_clear_q;
    assign game_over   = game_over_q;
endmodule

// File: tb/tb_brick_field_writer.sv
// Scoreboard bench for brick_field_writer: a reference model pushes expected outputs per driven
// cycle, which are popped and compared one cycle later; key playfield values are also checked directly.
module tb_brick_field_writer;
    localparam int BT = 1;
    localparam int BR = 4;
    localparam int PW = 4;
    localparam int SW = 8;
`ifdef BRICK_FIELD_CHECKER_EN
    localparam bit          CHECKER = 1'b1;
    localparam int          TOTAL   = 32;
    localparam logic [15:0] ROW1    = 16'hAAAA;
`else
    localparam bit          CHECKER = 1'b0;
    localparam int          TOTAL   = 64;
    localparam logic [15:0] ROW1    = 16'hFFFF;
`endif
    localparam int S_IDLE = 0, S_LOAD = 1, S_PLAY = 2, S_CLEAR = 3, S_OVER = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          tick = 1'b0;
    logic [3:0]    ball_r = '0, ball_c = '0, paddle_col = '0;
    logic [1:0]    ball_dir = '0;
    logic [191:0]  data;
    logic [SW-1:0] score;
    logic [7:0]    bricks_left;
    logic          level_clear, game_over;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [191:0] d;
        int           score;
        int           left;
        bit           lc;
        bit           go;
    } exp_t;
    exp_t exp_q[$];

    logic [191:0] m_data;
    int m_score, m_left, m_state, m_k;

    always #5 clock = ~clock;

    brick_field_writer #(.BRICK_TOP(BT), .BRICK_ROWS(BR), .PADDLE_W(PW), .SCORE_W(SW)) dut (
        .clock(clock), .reset(reset), .start(start), .tick(tick),
        .Ball_rowIndex(ball_r), .Ball_colIndex(ball_c), .Ball_direction(ball_dir),
        .paddle_col(paddle_col), .data(data), .score(score), .bricks_left(bricks_left),
        .level_clear(level_clear), .game_over(game_over)
    );

    task automatic chk_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data = '0; m_score = 0; m_left = 0; m_state = S_IDLE; m_k = 0;
    endtask

    function automatic bit m_brick(input int r, input int c);
        return (r >= BT) && (r < BT + BR) && (c >= 0) && (c < 16) && m_data[r*16 + c];
    endfunction

    task automatic model_step(input bit st, input bit tk, input int r, input int c,
                              input int dir, input int pc);
        logic [191:0] nd;
        int dr, dc, n, pcc;
        bit vb, hb, db;
        nd = m_data;
        if (m_state == S_LOAD || m_state == S_PLAY || m_state == S_CLEAR) begin
            pcc = (pc > 16 - PW) ? 16 - PW : pc;
            for (int col = 0; col < 16; col++) nd[176 + col] = (col >= pcc) && (col < pcc + PW);
        end
        if (st) begin
            if (m_state == S_IDLE || m_state == S_OVER) m_score = 0;
            m_state = S_LOAD;
            m_k = 0;
        end else if (m_state == S_LOAD) begin
            if (m_k == 0) for (int i = 0; i < 176; i++) nd[i] = 1'b0;
            for (int col = 0; col < 16; col++)
                nd[(BT + m_k)*16 + col] = !CHECKER || (((BT + m_k + col) % 2) == 0);
            if (m_k == BR - 1) begin
                m_left = 0;
                for (int rr = BT; rr < BT + BR; rr++)
                    for (int col = 0; col < 16; col++) if (nd[rr*16 + col]) m_left++;
                m_state = S_PLAY;
            end else begin
                m_k++;
            end
        end else if (m_state == S_PLAY && tk) begin
            dr = dir[1] ? 1 : -1;
            dc = dir[0] ? 1 : -1;
            vb = m_brick(r + dr, c);
            hb = m_brick(r, c + dc);
            db = m_brick(r + dr, c + dc);
            n = 0;
            if (vb || hb) begin
                if (vb) begin nd[(r + dr)*16 + c] = 1'b0; n++; end
                if (hb) begin nd[r*16 + c + dc] = 1'b0; n++; end
            end else if (db) begin
                nd[(r + dr)*16 + c + dc] = 1'b0; n++;
            end
            m_score = (m_score + n > 2**SW - 1) ? 2**SW - 1 : m_score + n;
            m_left -= n;
            if (m_left == 0) m_state = S_CLEAR;
            else if (r == 11) m_state = S_OVER;
        end
        m_data = nd;
    endtask

    task automatic push_exp();
        exp_t e;
        e.d = m_data; e.score = m_score; e.left = m_left;
        e.lc = (m_state == S_CLEAR); e.go = (m_state == S_OVER);
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk_eq({tag, ".sb_empty"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk_eq({tag, ".data"}, data, e.d);
        chk_eq({tag, ".score"}, score, e.score);
        chk_eq({tag, ".left"}, bricks_left, e.left);
        chk_eq({tag, ".level_clear"}, level_clear, e.lc);
        chk_eq({tag, ".game_over"}, game_over, e.go);
    endtask

    task automatic step(input string tag, input bit st, input bit tk, input int r, input int c,
                        input int dir, input int pc);
        @(negedge clock);
        start = st; tick = tk;
        ball_r = 4'(r); ball_c = 4'(c); ball_dir = 2'(dir); paddle_col = 4'(pc);
        model_step(st, tk, r, c, dir, pc);
        push_exp();
        @(posedge clock);
        #1;
        start = 1'b0; tick = 1'b0;
        pop_cmp(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int br, bc;
        model_reset();
        repeat (2) @(negedge clock);
        push_exp();
        pop_cmp("reset");
        reset = 1'b0;

        step("start", 1, 0, 0, 0, 0, 6);
        for (int i = 0; i < 4; i++) step("load", 0, 0, 0, 0, 0, 6);
        chk_eq("row1", data[16 +: 16], ROW1);
        chk_eq("row0", data[0 +: 16], 0);
        chk_eq("row5", data[80 +: 16], 0);
        chk_eq("row11", data[176 +: 16], 16'h03C0);
        chk_eq("left_load", bricks_left, TOTAL);
        chk_eq("score_load", score, 0);

        step("tick_v", 0, 1, 5, 7, 0, 6);
`ifndef BRICK_FIELD_CHECKER_EN
        chk_eq("v_bit", data[4*16 + 7], 0);
        chk_eq("score_v", score, 1);
        chk_eq("left_v", bricks_left, 63);
`endif
        step("tick_d", 0, 1, 5, 7, 0, 6);
`ifndef BRICK_FIELD_CHECKER_EN
        chk_eq("d_bit", data[4*16 + 6], 0);
        chk_eq("score_d", score, 2);
`endif
        step("tick_oob", 0, 1, 0, 0, 0, 6);
        step("tick_edge", 0, 1, 4, 15, 3, 6);

        step("pad15", 0, 0, 0, 0, 0, 15);
        chk_eq("row11_clamp", data[176 +: 16], 16'hF000);
        step("start_tick", 1, 1, 5, 5, 0, 15);
`ifndef BRICK_FIELD_CHECKER_EN
        chk_eq("no_clear", data[4*16 + 5], 1);
`endif
        for (int i = 0; i < 4; i++) step("load2", 0, 0, 0, 0, 0, 15);

        step("over", 0, 1, 11, 3, 0, 15);
        chk_eq("game_over", game_over, 1);
        step("over_tick", 0, 1, 5, 8, 0, 0);
        chk_eq("row11_frozen", data[176 +: 16], 16'hF000);
        step("over_tick2", 0, 1, 2, 8, 1, 0);

        step("restart", 1, 0, 0, 0, 0, 6);
        chk_eq("score_restart", score, 0);
        for (int i = 0; i < 4; i++) step("load3", 0, 0, 0, 0, 0, 6);
        chk_eq("left_reload", bricks_left, TOTAL);

        for (int it = 0; it < 200 && m_left > 0; it++) begin
            br = -1; bc = -1;
            for (int rr = BT + BR - 1; rr >= BT; rr--)
                for (int cc = 0; cc < 16; cc++)
                    if (br < 0 && m_data[rr*16 + cc]) begin br = rr; bc = cc; end
            step("clear", 0, 1, br + 1, bc, 1, 6);
        end
        chk_eq("left_zero", bricks_left, 0);
        chk_eq("level_clear", level_clear, 1);
        chk_eq("score_all", score, TOTAL);

        step("clear_tick", 0, 1, 5, 5, 0, 3);
        step("next_level", 1, 0, 0, 0, 0, 6);
        for (int i = 0; i < 4; i++) step("load4", 0, 0, 0, 0, 0, 6);
        chk_eq("score_kept", score, TOTAL);
        chk_eq("left_level2", bricks_left, TOTAL);
        chk_eq("row1_level2", data[16 +: 16], ROW1);

        step("start5", 1, 0, 0, 0, 0, 6);
        step("load5", 0, 0, 0, 0, 0, 6);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        #1;
        push_exp();
        pop_cmp("reset_mid_load");
        @(negedge clock);
        reset = 1'b0;
        step("idle_tick", 0, 1, 5, 7, 0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
